// File: rtl/digit_scanner.sv
// Multiplexed digit scanner: steps a one-hot select across NUM_DIGITS digits,
// showing each for TICKS_PER_DIGIT enabled cycles from a once-per-frame snapshot of N.
module digit_scanner #(
    parameter int NUM_DIGITS      = 4,
    parameter int DIGIT_W         = 4,
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   N,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    output logic [NUM_DIGITS-1:0]           sel,
    output logic [NUM_DIGITS-1:0]           an_n,
    output logic [DIGIT_W-1:0]              H,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int TICK_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]             tick_q, tick_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]         blank_q, blank_d;
    logic                          first_q, first_d;
    logic                          frame_done_q, frame_done_d;

    logic                          tick_end;
    logic                          last_digit;
    logic [NUM_DIGITS-1:0]         sel_dec;
    logic [DIGIT_W-1:0]            h_mux;

    assign tick_end   = (tick_q == TICK_LAST);
    assign last_digit = (idx_q == IDX_LAST);

    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        blank_d      = blank_mask;
        first_d      = 1'b0;
        frame_done_d = 1'b0;

        if (en) begin
            if (tick_end) begin
                tick_d = '0;
                if (last_digit) begin
                    idx_d        = '0;
                    snap_d       = N;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        // The first edge out of reset captures N so the display never starts from zeros.
        if (first_q) begin
            snap_d = N;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q       <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            blank_q      <= '1;
            first_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            blank_q      <= blank_d;
            first_q      <= first_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        sel_dec = '0;
        h_mux   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_dec[k] = 1'b1;
                h_mux      = snap_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign sel        = sel_dec & ~blank_q;
    assign an_n       = ~sel;
    assign H          = h_mux;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner (4 digits x 4 bits, 3-tick dwell); expectations are
// queued per driven cycle and compared by an independent monitor after each rising edge.
module tb_digit_scanner;

    localparam int ND  = 4;
    localparam int DW  = 4;
    localparam int TPD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [15:0]   n = '0;
    logic [3:0]    blank_mask = '0;
    logic [3:0]    sel;
    logic [3:0]    an_n;
    logic [3:0]    h;
    logic [1:0]    digit_idx;
    logic          frame_done;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] h;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    always #5 clk = ~clk;

    digit_scanner #(
        .NUM_DIGITS      (ND),
        .DIGIT_W         (DW),
        .TICKS_PER_DIGIT (TPD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .N          (n),
        .blank_mask (blank_mask),
        .sel        (sel),
        .an_n       (an_n),
        .H          (h),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] nv,
                                 input logic [3:0] bm, input logic [1:0] ei,
                                 input logic [3:0] eh, input logic [3:0] es, input logic ef);
        exp_t ex;
        @(negedge clk);
        rst_n      = r;
        en         = e;
        n          = nv;
        blank_mask = bm;
        ex.idx = ei;
        ex.h   = eh;
        ex.sel = es;
        ex.fd  = ef;
        exp_q.push_back(ex);
    endtask

    task automatic checkOutput(input exp_t ex);
        step++;
        checks++;
        if ({digit_idx, h, sel, an_n, frame_done} !== {ex.idx, ex.h, ex.sel, ~ex.sel, ex.fd}) begin
            errors++;
            $display("[TB] FAIL cycle%0d: got idx=%0d H=%h sel=%b an_n=%b fd=%b, expected idx=%0d H=%h sel=%b an_n=%b fd=%b",
                     step, digit_idx, h, sel, an_n, frame_done,
                     ex.idx, ex.h, ex.sel, ~ex.sel, ex.fd);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) applyStimulus(0, 0, 16'h0000, 4'b0000, 0, 4'h0, 4'b0000, 0);

        // Basic scan of 4321 with a frame wrap
        repeat (2) applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 0);
        repeat (3) applyStimulus(1, 1, 16'h4321, 4'b0000, 1, 4'h2, 4'b0010, 0);
        repeat (3) applyStimulus(1, 1, 16'h4321, 4'b0000, 2, 4'h3, 4'b0100, 0);
        repeat (3) applyStimulus(1, 1, 16'h4321, 4'b0000, 3, 4'h4, 4'b1000, 0);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 1);
        repeat (2) applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 0);
        repeat (3) applyStimulus(1, 1, 16'h4321, 4'b0000, 1, 4'h2, 4'b0010, 0);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 2, 4'h3, 4'b0100, 0);

        // New N mid-frame: old snapshot until the wrap
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0000, 2, 4'h3, 4'b0100, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 3, 4'h4, 4'b1000, 0);
        applyStimulus(1, 1, 16'hABCD, 4'b0000, 0, 4'hD, 4'b0001, 1);
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0000, 0, 4'hD, 4'b0001, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 1, 4'hC, 4'b0010, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 2, 4'hB, 4'b0100, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 3, 4'hA, 4'b1000, 0);
        applyStimulus(1, 1, 16'hABCD, 4'b0000, 0, 4'hD, 4'b0001, 1);

        // Blank digit 2: select drops, value and timing unchanged
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0100, 0, 4'hD, 4'b0001, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0100, 1, 4'hC, 4'b0010, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0100, 2, 4'hB, 4'b0000, 0);
        applyStimulus(1, 1, 16'hABCD, 4'b0100, 3, 4'hA, 4'b1000, 0);
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0000, 3, 4'hA, 4'b1000, 0);

        // Pause on the terminal tick of digit 3, then resume into the wrap
        repeat (10) applyStimulus(1, 0, 16'h4321, 4'b0000, 3, 4'hA, 4'b1000, 0);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 1);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 0);
        repeat (5) applyStimulus(1, 0, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 0);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 0, 4'h1, 4'b0001, 0);
        applyStimulus(1, 1, 16'h4321, 4'b0000, 1, 4'h2, 4'b0010, 0);

        // Reset at idx 3, tick 2, then restart with a full dwell
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0000, 1, 4'h2, 4'b0010, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 2, 4'h3, 4'b0100, 0);
        repeat (3) applyStimulus(1, 1, 16'hABCD, 4'b0000, 3, 4'h4, 4'b1000, 0);
        applyStimulus(0, 1, 16'hABCD, 4'b0000, 0, 4'h0, 4'b0000, 0);
        repeat (2) applyStimulus(1, 1, 16'hABCD, 4'b0000, 0, 4'hD, 4'b0001, 0);
        applyStimulus(1, 1, 16'hABCD, 4'b0000, 1, 4'hC, 4'b0010, 0);

        // Snapshot on the first edge after reset even with en low
        applyStimulus(0, 1, 16'h1234, 4'b0000, 0, 4'h0, 4'b0000, 0);
        repeat (2) applyStimulus(1, 0, 16'h1234, 4'b0000, 0, 4'h4, 4'b0001, 0);
        repeat (2) applyStimulus(1, 1, 16'h1234, 4'b0000, 0, 4'h4, 4'b0001, 0);
        applyStimulus(1, 1, 16'h1234, 4'b0000, 1, 4'h3, 4'b0010, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
